// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: request/grant handshakes of both masters plus the shared memory bus
interface mem_bus_arbiter_if #(parameter int BITS = 32);
    logic            m0_req;
    logic            m0_we;
    logic [BITS-1:0] m0_addr;
    logic [BITS-1:0] m0_wdata;
    logic            m0_gnt;
    logic            m0_ack;
    logic [BITS-1:0] m0_rdata;
    logic            m1_req;
    logic            m1_we;
    logic [BITS-1:0] m1_addr;
    logic [BITS-1:0] m1_wdata;
    logic            m1_gnt;
    logic            m1_ack;
    logic [BITS-1:0] m1_rdata;
    logic            bus_we;
    logic [BITS-1:0] bus_addr;
    logic [BITS-1:0] bus_wdata;
    logic [BITS-1:0] bus_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  bus_rdata,
        output m0_gnt, m0_ack, m0_rdata,
        output m1_gnt, m1_ack, m1_rdata,
        output bus_we, bus_addr, bus_wdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output bus_rdata,
        input  m0_gnt, m0_ack, m0_rdata,
        input  m1_gnt, m1_ack, m1_rdata,
        input  bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin, bounded-hold arbiter sharing one memory port between two masters.
// Optional beat counters are enabled by defining MEMARB_STATS_EN.
module mem_bus_arbiter #(
    parameter int BITS     = 32,
    parameter int MAX_HOLD = 4
`ifdef MEMARB_STATS_EN
    ,
    parameter int STAT_BITS = 16
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_bus_arbiter_if.slave     mb
`ifdef MEMARB_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [STAT_BITS-1:0] stat_beats0,
    output logic [STAT_BITS-1:0] stat_beats1
`endif
);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state, state_nx;
    logic            last, last_nx;
    logic [HW-1:0]   hold_cnt, hold_nx;
    logic            beat0, beat1;
    logic            own1, own_req, oth_req;
    logic            ack0, ack1;
    logic [BITS-1:0] rdata0, rdata1;

    assign mb.m0_gnt = (state == OWN0);
    assign mb.m1_gnt = (state == OWN1);
    assign beat0     = mb.m0_gnt & mb.m0_req;
    assign beat1     = mb.m1_gnt & mb.m1_req;
    assign own1      = (state == OWN1);
    assign own_req   = own1 ? mb.m1_req : mb.m0_req;
    assign oth_req   = own1 ? mb.m0_req : mb.m1_req;

    assign mb.bus_we    = beat0 ? mb.m0_we    : (beat1 & mb.m1_we);
    assign mb.bus_addr  = beat0 ? mb.m0_addr  : beat1 ? mb.m1_addr  : '0;
    assign mb.bus_wdata = beat0 ? mb.m0_wdata : beat1 ? mb.m1_wdata : '0;

    assign mb.m0_ack   = ack0;
    assign mb.m1_ack   = ack1;
    assign mb.m0_rdata = rdata0;
    assign mb.m1_rdata = rdata1;

    // ownership decision: round-robin tie break from IDLE, hand over on release or when the hold budget is spent
    always_comb begin
        state_nx = state;
        last_nx  = last;
        hold_nx  = hold_cnt;
        if (state == IDLE) begin
            if (mb.m0_req && mb.m1_req)
                state_nx = last ? OWN0 : OWN1;
            else if (mb.m0_req)
                state_nx = OWN0;
            else if (mb.m1_req)
                state_nx = OWN1;
            hold_nx = '0;
        end else if (!own_req) begin
            state_nx = oth_req ? (own1 ? OWN0 : OWN1) : IDLE;
            last_nx  = own1;
            hold_nx  = '0;
        end else if (oth_req && hold_cnt == HOLD_LAST) begin
            state_nx = own1 ? OWN0 : OWN1;
            last_nx  = own1;
            hold_nx  = '0;
        end else if (hold_cnt != HOLD_LAST) begin
            hold_nx = hold_cnt + 1'b1;
        end
    end

    // arbitration state register; last=1 after reset so master 0 wins the first tie
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            hold_cnt <= hold_nx;
        end
    end

    // completion pulse and read capture one cycle after each beat; reset drops an in-flight ack
    always_ff @(posedge clk) begin
        if (!reset) begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            ack0   <= beat0;
            ack1   <= beat1;
            rdata0 <= (beat0 && !mb.m0_we) ? mb.bus_rdata : rdata0;
            rdata1 <= (beat1 && !mb.m1_we) ? mb.bus_rdata : rdata1;
        end
    end

`ifdef MEMARB_STATS_EN
    // saturating per-master beat counters; clear takes priority over a same-cycle beat
    always_ff @(posedge clk) begin
        if (!reset || stat_clr) begin
            stat_beats0 <= '0;
            stat_beats1 <= '0;
        end else begin
            if (beat0 && stat_beats0 != '1)
                stat_beats0 <= stat_beats0 + 1'b1;
            if (beat1 && stat_beats1 != '1)
                stat_beats1 <= stat_beats1 + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus random traffic checked against a transaction-level arbiter model
module tb_mem_bus_arbiter;
    localparam int BITS     = 32;
    localparam int MAX_HOLD = 4;
`ifdef MEMARB_STATS_EN
    localparam int STAT_BITS = 4;
    logic                 stat_clr = 1'b0;
    logic [STAT_BITS-1:0] stat_beats0, stat_beats1;
    int                   e_st[2];
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic        req[2];
    logic        we[2];
    logic [31:0] addr[2];
    logic [31:0] wdata[2];

    logic [31:0] mem[256];
    logic [31:0] exp_mem[256];

    int          owner = -1;
    int          run = 0;
    int          last_own = 1;
    logic        e_ack[2];
    logic [31:0] e_rdata[2];
    bit          did_beat[2];

    mem_bus_arbiter_if #(.BITS(BITS)) mb ();

    mem_bus_arbiter #(
        .BITS(BITS),
        .MAX_HOLD(MAX_HOLD)
`ifdef MEMARB_STATS_EN
        ,
        .STAT_BITS(STAT_BITS)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .mb(mb)
`ifdef MEMARB_STATS_EN
        ,
        .stat_clr(stat_clr),
        .stat_beats0(stat_beats0),
        .stat_beats1(stat_beats1)
`endif
    );

    assign mb.m0_req   = req[0];
    assign mb.m0_we    = we[0];
    assign mb.m0_addr  = addr[0];
    assign mb.m0_wdata = wdata[0];
    assign mb.m1_req   = req[1];
    assign mb.m1_we    = we[1];
    assign mb.m1_addr  = addr[1];
    assign mb.m1_wdata = wdata[1];

    always_comb mb.bus_rdata = (mb.bus_addr < 32'h400) ? mem[mb.bus_addr[9:2]] : 32'h0;

    always @(posedge clk)
        if (mb.bus_we && mb.bus_addr < 32'h400) mem[mb.bus_addr[9:2]] <= mb.bus_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // transaction-level reference: who owns the bus, how many beats it has had, who owned last
    always @(posedge clk) begin
        bit bt[2];
        for (int i = 0; i < 2; i++) bt[i] = (owner == i) && req[i];
        for (int i = 0; i < 2; i++) begin
            did_beat[i] = bt[i];
            e_ack[i] = bt[i];
            if (bt[i] && we[i] && addr[i] < 32'h400) exp_mem[addr[i][9:2]] = wdata[i];
            if (bt[i] && !we[i]) e_rdata[i] = (addr[i] < 32'h400) ? exp_mem[addr[i][9:2]] : 32'h0;
`ifdef MEMARB_STATS_EN
            if (stat_clr) e_st[i] = 0;
            else if (bt[i] && e_st[i] < (1 << STAT_BITS) - 1) e_st[i]++;
`endif
        end
        if (owner < 0) begin
            if (req[0] && req[1]) owner = 1 - last_own;
            else if (req[0]) owner = 0;
            else if (req[1]) owner = 1;
            run = 0;
        end else if (!req[owner]) begin
            last_own = owner;
            owner = req[1 - owner] ? 1 - owner : -1;
            run = 0;
        end else begin
            if (run < MAX_HOLD) run++;
            if (req[1 - owner] && run >= MAX_HOLD) begin
                last_own = owner;
                owner = 1 - owner;
                run = 0;
            end
        end
        if (!reset) begin
            owner = -1;
            last_own = 1;
            run = 0;
            for (int i = 0; i < 2; i++) begin
                e_ack[i] = 1'b0;
                e_rdata[i] = 32'h0;
`ifdef MEMARB_STATS_EN
                e_st[i] = 0;
`endif
            end
        end
    end

    // every-cycle comparison of all DUT outputs against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            bit b0, b1;
            b0 = (owner == 0) && req[0];
            b1 = (owner == 1) && req[1];
            check("m0_gnt", 32'(mb.m0_gnt), 32'(owner == 0));
            check("m1_gnt", 32'(mb.m1_gnt), 32'(owner == 1));
            check("m0_ack", 32'(mb.m0_ack), 32'(e_ack[0]));
            check("m1_ack", 32'(mb.m1_ack), 32'(e_ack[1]));
            check("m0_rdata", mb.m0_rdata, e_rdata[0]);
            check("m1_rdata", mb.m1_rdata, e_rdata[1]);
            check("bus_we", 32'(mb.bus_we), b0 ? 32'(we[0]) : b1 ? 32'(we[1]) : 32'h0);
            check("bus_addr", mb.bus_addr, b0 ? addr[0] : b1 ? addr[1] : 32'h0);
            check("bus_wdata", mb.bus_wdata, b0 ? wdata[0] : b1 ? wdata[1] : 32'h0);
`ifdef MEMARB_STATS_EN
            check("stat_beats0", 32'(stat_beats0), 32'(e_st[0]));
            check("stat_beats1", 32'(stat_beats1), 32'(e_st[1]));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0;
            we[i] = 1'b0;
            addr[i] = 32'h0;
            wdata[i] = 32'h0;
            e_ack[i] = 1'b0;
            e_rdata[i] = 32'h0;
`ifdef MEMARB_STATS_EN
            e_st[i] = 0;
`endif
        end
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            exp_mem[i] = mem[i];
        end
        mem[4] = 32'hDEAD;
        exp_mem[4] = 32'hDEAD;
        do_reset();
        chk_en = 1'b1;
        @(negedge clk);
        check("reset m0_gnt", 32'(mb.m0_gnt), 32'h0);
        check("reset m1_rdata", mb.m1_rdata, 32'h0);

        // single read from IDLE
        tick();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
        tick();
        @(negedge clk);
        check("t1 gnt cycle1", 32'(mb.m0_gnt), 32'h1);
        check("t1 bus_addr", mb.bus_addr, 32'h10);
        tick();
        req[0] = 1'b0;
        @(negedge clk);
        check("t1 ack cycle2", 32'(mb.m0_ack), 32'h1);
        check("t1 rdata", mb.m0_rdata, 32'hDEAD);

        // both masters request continuously: 4 beats each, alternating
        do_reset();
        we[0] = 1'b0; addr[0] = 32'h100;
        we[1] = 1'b0; addr[1] = 32'h200;
        req[0] = 1'b1; req[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            bit m0_turn;
            tick();
            @(negedge clk);
            m0_turn = (((k - 1) / 4) % 2) == 0;
            check("t2 m0_gnt", 32'(mb.m0_gnt), 32'(m0_turn));
            check("t2 m1_gnt", 32'(mb.m1_gnt), 32'(!m0_turn));
            check("t2 bus_addr", mb.bus_addr, m0_turn ? 32'h100 : 32'h200);
        end

        // lone writer keeps the bus, then the other master reads the value back
        do_reset();
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h55;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            check("t3 m0_gnt held", 32'(mb.m0_gnt), 32'h1);
            check("t3 bus_we", 32'(mb.bus_we), 32'h1);
        end
        tick();
        req[0] = 1'b0;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20;
        tick();
        @(negedge clk);
        check("t3 m1_gnt", 32'(mb.m1_gnt), 32'h1);
        tick();
        req[1] = 1'b0;
        @(negedge clk);
        check("t3 m1_ack", 32'(mb.m1_ack), 32'h1);
        check("t3 m1_rdata", mb.m1_rdata, 32'h55);

        // request withdrawn in the grant cycle: no beat, no ack
        do_reset();
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'h7;
        tick();
        req[1] = 1'b0;
        @(negedge clk);
        check("t4 m1_gnt", 32'(mb.m1_gnt), 32'h1);
        check("t4 bus_we", 32'(mb.bus_we), 32'h0);
        check("t4 bus_addr", mb.bus_addr, 32'h0);
        tick();
        @(negedge clk);
        check("t4 m1_ack", 32'(mb.m1_ack), 32'h0);
        check("t4 idle", 32'(mb.m1_gnt), 32'h0);

        // reset in the middle of a burst, then m0 wins the first tie
        do_reset();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5 ack before reset", 32'(mb.m0_ack), 32'h1);
        check("t5 rdata before reset", mb.m0_rdata, 32'hDEAD);
        tick();
        reset = 1'b1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40;
        @(negedge clk);
        check("t5 gnt after reset", 32'(mb.m0_gnt), 32'h0);
        check("t5 ack dropped", 32'(mb.m0_ack), 32'h0);
        check("t5 rdata cleared", mb.m0_rdata, 32'h0);
        tick();
        @(negedge clk);
        check("t5 m0 first", 32'(mb.m0_gnt), 32'h1);
        check("t5 m1 waits", 32'(mb.m1_gnt), 32'h0);

`ifdef MEMARB_STATS_EN
        // counter saturation and clear
        do_reset();
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
        repeat (21) tick();
        req[1] = 1'b0;
        @(negedge clk);
        check("t6 saturated", 32'(stat_beats1), 32'd15);
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        @(negedge clk);
        check("t6 cleared", 32'(stat_beats1), 32'd0);
`endif

        // random traffic; masters hold their request until granted, sometimes withdraw once granted
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            tick();
            reset = ($urandom_range(0, 299) != 0);
`ifdef MEMARB_STATS_EN
            stat_clr = ($urandom_range(0, 49) == 0);
`endif
            for (int i = 0; i < 2; i++) begin
                bit g;
                g = (i == 0) ? mb.m0_gnt : mb.m1_gnt;
                if (!req[i] || did_beat[i]) begin
                    req[i] = ($urandom_range(0, 99) < 60);
                    we[i] = 1'($urandom_range(0, 1));
                    addr[i] = 32'($urandom_range(0, 319)) << 2;
                    wdata[i] = $urandom;
                end else if (g && $urandom_range(0, 9) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        tick();
        req[0] = 1'b0;
        req[1] = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
